// File: rtl/rpc_cmd_pkg.sv
// Shared types and constants for the AXI command front end.
// Widths, bus payload structs and the chop-size helper used by axi_cmd_arbiter.
package rpc_cmd_pkg;

  localparam int unsigned AxiAddrWidth   = 32;
  localparam int unsigned AxiIdWidth     = 4;
  localparam int unsigned AxiLenWidth    = 8;
  localparam int unsigned DramAddrWidth  = 20;
  localparam int unsigned DramLenWidth   = 6;
  localparam int unsigned OrdFifoDepth   = 4;
  localparam int unsigned WordBytes      = 32;
  localparam int unsigned MaxChunkBeats  = 64;
  localparam int unsigned WordOffsetBits = $clog2(WordBytes);
  localparam int unsigned RemWidth       = AxiLenWidth + 1;
  localparam int unsigned ChunkWidth     = DramLenWidth + 1;

  typedef enum logic {
    ArbIdle  = 1'b0,
    ArbIssue = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                     cmd_valid;
    logic                     is_write;
    logic [DramAddrWidth-1:0] addr;
    logic [DramLenWidth-1:0]  len;
  } cmd_req_t;

  typedef struct packed {
    logic cmd_ready;
  } cmd_rsp_t;

  typedef struct packed {
    logic                    is_write;
    logic [AxiIdWidth-1:0]   id;
    logic [DramLenWidth-1:0] len;
    logic                    last;
  } ord_entry_t;

  // Beats carried by the next chop: the remaining count capped at one DRAM burst.
  function automatic logic [ChunkWidth-1:0] chunk_beats(input logic [RemWidth-1:0] rem);
    return (rem > RemWidth'(MaxChunkBeats)) ? ChunkWidth'(MaxChunkBeats) : ChunkWidth'(rem);
  endfunction

endpackage

// File: rtl/cmd_ord_fifo.sv
// Synchronous FIFO of order entries consumed by the data/response path.
// Head data reads as zero while empty; a pop on empty is ignored.
module cmd_ord_fifo
  import rpc_cmd_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  ord_entry_t push_data_i,
  input  logic       pop_i,
  output ord_entry_t pop_data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned CountWidth = PtrWidth + 1;

  ord_entry_t            mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q;
  logic [PtrWidth-1:0]   rd_ptr_q;
  logic [CountWidth-1:0] count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (count_q == CountWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CountWidth'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CountWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Arbitrates AXI AW/AR, chops bursts into <=64-beat DRAM commands and logs order info.
// Define RPC_CMD_WR_PRIO_EN for fixed write priority instead of round-robin.
module axi_cmd_arbiter
  import rpc_cmd_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     aw_valid_i,
  output logic                     aw_ready_o,
  input  logic [AxiAddrWidth-1:0]  aw_addr_i,
  input  logic [AxiLenWidth-1:0]   aw_len_i,
  input  logic [AxiIdWidth-1:0]    aw_id_i,
  input  logic                     ar_valid_i,
  output logic                     ar_ready_o,
  input  logic [AxiAddrWidth-1:0]  ar_addr_i,
  input  logic [AxiLenWidth-1:0]   ar_len_i,
  input  logic [AxiIdWidth-1:0]    ar_id_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic                     cmd_is_write_o,
  output logic [DramAddrWidth-1:0] cmd_addr_o,
  output logic [DramLenWidth-1:0]  cmd_len_o,
  output logic                     ord_valid_o,
  input  logic                     ord_ready_i,
  output logic                     ord_is_write_o,
  output logic [AxiIdWidth-1:0]    ord_id_o,
  output logic [DramLenWidth-1:0]  ord_len_o,
  output logic                     ord_last_o
);

  arb_state_e               state_q, state_d;
  logic [DramAddrWidth-1:0] addr_q, addr_d;
  logic [RemWidth-1:0]      rem_q, rem_d;
  logic [AxiIdWidth-1:0]    id_q, id_d;
  logic                     is_write_q, is_write_d;
  logic                     rr_w_q, rr_w_d;

  logic                  grant_w;
  logic                  grant_r;
  logic [ChunkWidth-1:0] chunk;
  logic                  chunk_last;
  logic                  cmd_fire;
  logic                  ord_push;
  logic                  ord_full;
  logic                  ord_empty;
  cmd_req_t              cmd_req;
  cmd_rsp_t              cmd_rsp;
  ord_entry_t            ord_push_entry;
  ord_entry_t            ord_head;

`ifdef RPC_CMD_WR_PRIO_EN
  logic unused_rr;
  assign unused_rr = rr_w_q;
  assign grant_w   = aw_valid_i;
  assign grant_r   = ar_valid_i && !aw_valid_i;
`else
  assign grant_w = aw_valid_i && (!ar_valid_i || rr_w_q);
  assign grant_r = ar_valid_i && (!aw_valid_i || !rr_w_q);
`endif

  // Byte offset within a 32B word and address bits above the DRAM range carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr_i[AxiAddrWidth-1:DramAddrWidth+WordOffsetBits],
                              aw_addr_i[WordOffsetBits-1:0],
                              ar_addr_i[AxiAddrWidth-1:DramAddrWidth+WordOffsetBits],
                              ar_addr_i[WordOffsetBits-1:0]};

  assign chunk       = chunk_beats(rem_q);
  assign chunk_last  = (rem_q <= RemWidth'(MaxChunkBeats));
  assign cmd_rsp.cmd_ready = cmd_ready_i;
  assign cmd_fire    = cmd_req.cmd_valid && cmd_rsp.cmd_ready;

  // Command outputs are held from registers and forced to zero outside ISSUE.
  always_comb begin
    cmd_req.cmd_valid = (state_q == ArbIssue) && !ord_full;
    cmd_req.is_write  = 1'b0;
    cmd_req.addr      = '0;
    cmd_req.len       = '0;
    if (state_q == ArbIssue) begin
      cmd_req.is_write = is_write_q;
      cmd_req.addr     = addr_q;
      cmd_req.len      = DramLenWidth'(chunk - ChunkWidth'(1));
    end
  end

  always_comb begin
    ord_push_entry.is_write = is_write_q;
    ord_push_entry.id       = id_q;
    ord_push_entry.len      = cmd_req.len;
    ord_push_entry.last     = chunk_last;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    id_d       = id_q;
    is_write_d = is_write_q;
    rr_w_d     = rr_w_q;
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    ord_push   = 1'b0;
    case (state_q)
      ArbIdle: begin
        if (grant_w) begin
          aw_ready_o = 1'b1;
          addr_d     = aw_addr_i[DramAddrWidth+WordOffsetBits-1:WordOffsetBits];
          rem_d      = RemWidth'(aw_len_i) + RemWidth'(1);
          id_d       = aw_id_i;
          is_write_d = 1'b1;
          rr_w_d     = 1'b0;
          state_d    = ArbIssue;
        end else if (grant_r) begin
          ar_ready_o = 1'b1;
          addr_d     = ar_addr_i[DramAddrWidth+WordOffsetBits-1:WordOffsetBits];
          rem_d      = RemWidth'(ar_len_i) + RemWidth'(1);
          id_d       = ar_id_i;
          is_write_d = 1'b0;
          rr_w_d     = 1'b1;
          state_d    = ArbIssue;
        end
      end
      ArbIssue: begin
        if (cmd_fire) begin
          ord_push = 1'b1;
          addr_d   = addr_q + DramAddrWidth'(chunk);
          rem_d    = rem_q - RemWidth'(chunk);
          if (chunk_last) state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ArbIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      id_q       <= '0;
      is_write_q <= 1'b0;
      rr_w_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      id_q       <= id_d;
      is_write_q <= is_write_d;
      rr_w_q     <= rr_w_d;
    end
  end

  cmd_ord_fifo #(
    .Depth(OrdFifoDepth)
  ) u_ord_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (ord_push),
    .push_data_i (ord_push_entry),
    .pop_i       (ord_ready_i),
    .pop_data_o  (ord_head),
    .full_o      (ord_full),
    .empty_o     (ord_empty)
  );

  assign cmd_valid_o    = cmd_req.cmd_valid;
  assign cmd_is_write_o = cmd_req.is_write;
  assign cmd_addr_o     = cmd_req.addr;
  assign cmd_len_o      = cmd_req.len;
  assign ord_valid_o    = !ord_empty;
  assign ord_is_write_o = ord_head.is_write;
  assign ord_id_o       = ord_head.id;
  assign ord_len_o      = ord_head.len;
  assign ord_last_o     = ord_head.last;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Self-checking bench for axi_cmd_arbiter: directed vector table, corner sequences
// and randomized bursts compared against a burst-level chopping model.
module tb_axi_cmd_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        aw_valid_i, aw_ready_o;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [3:0]  aw_id_i;
  logic        ar_valid_i, ar_ready_o;
  logic [31:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [3:0]  ar_id_i;
  logic        cmd_valid_o, cmd_ready_i, cmd_is_write_o;
  logic [19:0] cmd_addr_o;
  logic [5:0]  cmd_len_o;
  logic        ord_valid_o, ord_ready_i, ord_is_write_o, ord_last_o;
  logic [3:0]  ord_id_o;
  logic [5:0]  ord_len_o;

  axi_cmd_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_id_i(aw_id_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_id_i(ar_id_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_is_write_o(cmd_is_write_o),
    .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o),
    .ord_valid_o(ord_valid_o), .ord_ready_i(ord_ready_i), .ord_is_write_o(ord_is_write_o),
    .ord_id_o(ord_id_o), .ord_len_o(ord_len_o), .ord_last_o(ord_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit w; int addr; int len; } cmd_t;
  typedef struct { bit w; int id; int len; bit last; } ord_t;
  typedef struct {
    bit w; logic [31:0] addr; int len; int id;
    int n; int a0; int l0; int a1; int l1;
  } vec_t;

  cmd_t cmd_log[$];
  ord_t ord_log[$];
  cmd_t exp_cmd[$];
  ord_t exp_ord[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   rand_run;

  // Handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (cmd_valid_o && cmd_ready_i)
        cmd_log.push_back('{cmd_is_write_o, int'(cmd_addr_o), int'(cmd_len_o)});
      if (ord_valid_o && ord_ready_i)
        ord_log.push_back('{ord_is_write_o, int'(ord_id_o), int'(ord_len_o), ord_last_o});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    ord_log.delete();
    exp_cmd.delete();
    exp_ord.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    cmd_ready_i = 1'b0; ord_ready_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    clear_logs();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd_side"}, 32'({aw_ready_o, ar_ready_o, cmd_valid_o, cmd_is_write_o,
                                 cmd_addr_o, cmd_len_o}), 32'd0);
    chk({tag, "_ord_side"}, 32'({ord_valid_o, ord_is_write_o, ord_id_o, ord_len_o,
                                 ord_last_o}), 32'd0);
  endtask

  // Presents one burst on AW (w=1) or AR and waits for its handshake.
  task automatic send_axi(input bit w, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, output bit ok);
    ok = 1'b0;
    if (w) begin
      aw_valid_i = 1'b1; aw_addr_i = addr; aw_len_i = len; aw_id_i = id;
    end else begin
      ar_valid_i = 1'b1; ar_addr_i = addr; ar_len_i = len; ar_id_i = id;
    end
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk_i);
      if (w ? aw_ready_o : ar_ready_o) ok = 1'b1;
      step();
    end
    aw_valid_i = 1'b0;
    ar_valid_i = 1'b0;
  endtask

  // Reference: split beats into <=64 chunks, word address = byte/32 modulo 2^20.
  function automatic void model_burst(bit w, logic [31:0] addr, int len, int id);
    int beats = len + 1;
    int word  = int'((addr / 32) % 32'h100000);
    while (beats > 0) begin
      int c = (beats > 64) ? 64 : beats;
      exp_cmd.push_back('{w, word, c - 1});
      exp_ord.push_back('{w, id, c - 1, beats <= 64});
      word  = (word + c) % 32'h100000;
      beats = beats - c;
    end
  endfunction

  task automatic compare_logs(input string tag);
    chk({tag, "_cmd_count"}, cmd_log.size(), exp_cmd.size());
    chk({tag, "_ord_count"}, ord_log.size(), exp_ord.size());
    for (int i = 0; i < cmd_log.size() && i < exp_cmd.size(); i++) begin
      chk({tag, "_cmd_wr"},   32'(cmd_log[i].w), 32'(exp_cmd[i].w));
      chk({tag, "_cmd_addr"}, cmd_log[i].addr, exp_cmd[i].addr);
      chk({tag, "_cmd_len"},  cmd_log[i].len,  exp_cmd[i].len);
    end
    for (int i = 0; i < ord_log.size() && i < exp_ord.size(); i++) begin
      chk({tag, "_ord_wr"},   32'(ord_log[i].w), 32'(exp_ord[i].w));
      chk({tag, "_ord_id"},   ord_log[i].id,  exp_ord[i].id);
      chk({tag, "_ord_len"},  ord_log[i].len, exp_ord[i].len);
      chk({tag, "_ord_last"}, 32'(ord_log[i].last), 32'(exp_ord[i].last));
    end
  endtask

  initial begin
    bit ok;
    bit grants[3];
    int ng;

    vecs[0] = '{1'b0, 32'h0000_0040,   3,  5, 1, 32'h00002, 3,  0,       0};
    vecs[1] = '{1'b1, 32'h0000_0000, 127,  3, 2, 32'h00000, 63, 32'h40,  63};
    vecs[2] = '{1'b1, 32'h0000_1000,   0, 10, 1, 32'h00080, 0,  0,       0};
    vecs[3] = '{1'b0, 32'h0000_0020,  64,  1, 2, 32'h00001, 63, 32'h41,  0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 127,  9, 2, 32'hFFFFF, 63, 32'h3F,  63};
    vecs[5] = '{1'b1, 32'h0000_07FF,  63, 15, 1, 32'h0003F, 63, 0,       0};

    aw_addr_i = '0; aw_len_i = '0; aw_id_i = '0;
    ar_addr_i = '0; ar_len_i = '0; ar_id_i = '0;
    do_reset();
    @(negedge clk_i);
    check_zero("reset");
    step();

    // Directed vector table: single bursts, expected chops written out by hand.
    foreach (vecs[v]) begin
      clear_logs();
      cmd_ready_i = 1'b1; ord_ready_i = 1'b1;
      send_axi(vecs[v].w, vecs[v].addr, 8'(vecs[v].len), 4'(vecs[v].id), ok);
      chk("vec_axi_handshake", 32'(ok), 32'd1);
      repeat (20) step();
      chk("vec_cmd_count", cmd_log.size(), vecs[v].n);
      chk("vec_ord_count", ord_log.size(), vecs[v].n);
      for (int k = 0; k < vecs[v].n && k < cmd_log.size() && k < ord_log.size(); k++) begin
        chk("vec_cmd_wr",   32'(cmd_log[k].w), 32'(vecs[v].w));
        chk("vec_cmd_addr", cmd_log[k].addr, (k == 0) ? vecs[v].a0 : vecs[v].a1);
        chk("vec_cmd_len",  cmd_log[k].len,  (k == 0) ? vecs[v].l0 : vecs[v].l1);
        chk("vec_ord_id",   ord_log[k].id, vecs[v].id);
        chk("vec_ord_wr",   32'(ord_log[k].w), 32'(vecs[v].w));
        chk("vec_ord_len",  ord_log[k].len, (k == 0) ? vecs[v].l0 : vecs[v].l1);
        chk("vec_ord_last", 32'(ord_log[k].last), 32'(k == vecs[v].n - 1));
      end
    end

    // Both channels held valid: round-robin W,R,W from reset, or W,W,W with write priority.
    do_reset();
    cmd_ready_i = 1'b1; ord_ready_i = 1'b1;
    aw_valid_i = 1'b1; aw_addr_i = 32'h100; aw_len_i = 8'd0; aw_id_i = 4'd1;
    ar_valid_i = 1'b1; ar_addr_i = 32'h200; ar_len_i = 8'd0; ar_id_i = 4'd2;
    ng = 0;
    for (int i = 0; i < 60 && ng < 3; i++) begin
      @(negedge clk_i);
      if (aw_ready_o && ar_ready_o) chk("arb_double_grant", 32'd1, 32'd0);
      if (aw_ready_o) begin grants[ng] = 1'b1; ng++; end
      else if (ar_ready_o) begin grants[ng] = 1'b0; ng++; end
      step();
    end
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    chk("arb_grant_count", ng, 3);
    chk("arb_grant0_w", 32'(grants[0]), 32'd1);
`ifdef RPC_CMD_WR_PRIO_EN
    chk("arb_grant1_w", 32'(grants[1]), 32'd1);
    chk("arb_grant2_w", 32'(grants[2]), 32'd1);
`else
    chk("arb_grant1_r", 32'(grants[1]), 32'd0);
    chk("arb_grant2_w", 32'(grants[2]), 32'd1);
`endif
    repeat (10) step();

    // Order FIFO full blocks the fifth command until a single pop.
    do_reset();
    cmd_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_axi(1'b0, 32'h100 + 32'(k) * 32, 8'd0, 4'(k), ok);
      chk("full_axi_handshake", 32'(ok), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("full_cmd_valid_low", 32'(cmd_valid_o), 32'd0);
      chk("full_ord_head_id", 32'(ord_id_o), 32'd0);
      step();
    end
    chk("full_cmd_count", cmd_log.size(), 4);
    ord_ready_i = 1'b1;
    step();
    ord_ready_i = 1'b0;
    @(negedge clk_i);
    chk("full_5th_valid", 32'(cmd_valid_o), 32'd1);
    chk("full_5th_addr", 32'(cmd_addr_o), 32'd12);
    chk("full_ord_head_after_pop", 32'(ord_id_o), 32'd1);
    step(); step();
    chk("full_cmd_count_after", cmd_log.size(), 5);

    // Stalled splitter: command held stable, nothing pushed, AW not accepted.
    do_reset();
    send_axi(1'b1, 32'h400, 8'd127, 4'd7, ok);
    chk("stall_axi_handshake", 32'(ok), 32'd1);
    aw_valid_i = 1'b1; aw_addr_i = 32'h800; aw_len_i = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_cmd", 32'({cmd_valid_o, cmd_is_write_o, cmd_addr_o, cmd_len_o}),
          32'({1'b1, 1'b1, 20'h20, 6'd63}));
      chk("stall_no_push", 32'(ord_valid_o), 32'd0);
      chk("stall_aw_ready_low", 32'(aw_ready_o), 32'd0);
      step();
    end
    aw_valid_i = 1'b0;
    cmd_ready_i = 1'b1;
    repeat (6) step();
    exp_cmd.delete(); exp_ord.delete();
    model_burst(1'b1, 32'h400, 127, 7);
    ord_ready_i = 1'b1;
    repeat (6) step();
    compare_logs("stall");

    // Reset between the two chops of a 128-beat write drops the remainder.
    do_reset();
    cmd_ready_i = 1'b1;
    send_axi(1'b1, 32'h2000, 8'd127, 4'd3, ok);
    chk("rstmid_axi_handshake", 32'(ok), 32'd1);
    step();
    cmd_ready_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_zero("rstmid");
    step();
    chk("rstmid_first_chop_only", cmd_log.size(), 1);
    cmd_ready_i = 1'b1;
    repeat (5) step();
    @(negedge clk_i);
    chk("rstmid_stays_idle", 32'(cmd_valid_o), 32'd0);
    step();
    chk("rstmid_no_more_cmds", cmd_log.size(), 1);

    // Random bursts with random back-pressure on both downstream interfaces.
    do_reset();
    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          bit          w    = 1'($urandom_range(0, 1));
          logic [31:0] addr = $urandom;
          int          len  = int'($urandom_range(0, 127));
          int          id   = int'($urandom_range(0, 15));
          model_burst(w, addr, len, id);
          send_axi(w, addr, 8'(len), 4'(id), ok);
          chk("rand_axi_handshake", 32'(ok), 32'd1);
          repeat ($urandom_range(0, 2)) step();
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          cmd_ready_i = ($urandom_range(0, 3) != 0);
          ord_ready_i = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    cmd_ready_i = 1'b1; ord_ready_i = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (cmd_log.size() >= exp_cmd.size() && ord_log.size() >= exp_ord.size()) break;
      step();
    end
    repeat (5) step();
    compare_logs("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
